// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller.
// Holds the MDU state encoding and the per-priority control words.
package pipe_hazard_ctrl_pkg;

   localparam int REG_ZERO = 0;

   typedef enum logic [1:0] {
      MDU_IDLE = 2'b00,
      MDU_BUSY = 2'b01
   } mdu_state_t;

   typedef enum logic [1:0] {
      CTRL_REDIR,
      CTRL_STALL,
      CTRL_FETCH,
      CTRL_RUN
   } ctrl_sel_t;

   typedef struct packed {
      logic pc_write;
      logic ifid_write;
      logic ifid_flush;
      logic idex_bubble;
   } ctrl_t;

   function automatic ctrl_t ctrl_of(input ctrl_sel_t sel);
      ctrl_t c;
      c = '{pc_write: 1'b1, ifid_write: 1'b1,
            ifid_flush: 1'b0, idex_bubble: 1'b0};
      unique case (sel)
         CTRL_REDIR: c = '{1'b1, 1'b1, 1'b1, 1'b1};
         CTRL_STALL: c = '{1'b0, 1'b0, 1'b0, 1'b1};
         CTRL_FETCH: c = '{1'b0, 1'b1, 1'b1, 1'b0};
         CTRL_RUN:   c = '{1'b1, 1'b1, 1'b0, 1'b0};
         default:    c = '{1'b1, 1'b1, 1'b0, 1'b0};
      endcase
      return c;
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EX hazard inputs and pipeline enables.
// master drives the pipeline-side inputs, slave is the controller.
interface pipe_hazard_ctrl_if #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
);
   logic [REG_AW-1:0] i_id_rs;
   logic [REG_AW-1:0] i_id_rt;
   logic              i_id_uses_rs;
   logic              i_id_uses_rt;
   logic              i_id_mdu_start;
   logic              i_id_mdu_use;
   logic              i_ex_memread;
   logic [REG_AW-1:0] i_ex_rd;
   logic              i_ex_redirect;
   logic              i_imem_ready;
   logic              o_pc_write;
   logic              o_ifid_write;
   logic              o_ifid_flush;
   logic              o_idex_bubble;
   logic              o_mdu_busy;
   logic [CNT_W-1:0]  o_stall_cnt;

   modport master (
      output i_id_rs, i_id_rt, i_id_uses_rs, i_id_uses_rt,
      output i_id_mdu_start, i_id_mdu_use, i_ex_memread,
      output i_ex_rd, i_ex_redirect, i_imem_ready,
      input  o_pc_write, o_ifid_write, o_ifid_flush,
      input  o_idex_bubble, o_mdu_busy, o_stall_cnt
   );

   modport slave (
      input  i_id_rs, i_id_rt, i_id_uses_rs, i_id_uses_rt,
      input  i_id_mdu_start, i_id_mdu_use, i_ex_memread,
      input  i_ex_rd, i_ex_redirect, i_imem_ready,
      output o_pc_write, o_ifid_write, o_ifid_flush,
      output o_idex_bubble, o_mdu_busy, o_stall_cnt
   );
endinterface

// File: rtl/pipe_hazard_ctrl_mdu_scoreboard.sv
// Multi-cycle mult/div scoreboard: busy for MDU_LAT cycles after a start.
// Busy is registered so it is glitch-free into the hazard logic.
module mdu_scoreboard
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int MDU_LAT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_start,
   output logic o_busy
);
   localparam int CW = $clog2(MDU_LAT + 1);

   mdu_state_t    r_state;
   logic [CW-1:0] r_cnt;
   logic          r_busy;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= MDU_IDLE;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            MDU_IDLE: begin
               if (i_start) begin
                  r_state <= MDU_BUSY;
                  r_cnt   <= CW'(MDU_LAT);
                  r_busy  <= 1'b1;
               end
            end
            MDU_BUSY: begin
               if (r_cnt <= CW'(1)) begin
                  r_state <= MDU_IDLE;
                  r_cnt   <= '0;
                  r_busy  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            default: begin
               r_state <= MDU_IDLE;
               r_cnt   <= '0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_busy = r_busy;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: PC/IF-ID enables, flush and ID/EX bubble
// from load-use, MDU, redirect and fetch-wait hazards, plus a stall counter.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int MDU_LAT = 4,
   parameter int REG_AW  = 5,
   parameter int CNT_W   = 16
) (
   input logic              clk,
   input logic              rst,
   pipe_hazard_ctrl_if.slave bus
);
   logic             w_load_use;
   logic             w_mdu_haz;
   logic             w_mdu_busy;
   logic             w_start;
   ctrl_sel_t        w_sel;
   ctrl_t            w_ctrl;
   logic [CNT_W-1:0] r_stall_cnt;

   assign w_load_use = bus.i_ex_memread
                     & (bus.i_ex_rd != REG_AW'(REG_ZERO))
                     & ((bus.i_id_uses_rs & (bus.i_id_rs == bus.i_ex_rd))
                      | (bus.i_id_uses_rt & (bus.i_id_rt == bus.i_ex_rd)));

   assign w_mdu_haz = w_mdu_busy
                    & (bus.i_id_mdu_start | bus.i_id_mdu_use);

   always_comb begin
      w_sel = CTRL_RUN;
      if (bus.i_ex_redirect)
         w_sel = CTRL_REDIR;
      else if (w_load_use | w_mdu_haz)
         w_sel = CTRL_STALL;
      else if (!bus.i_imem_ready)
         w_sel = CTRL_FETCH;
   end

   // Reset holds the front end frozen with a NOP in IF/ID and ID/EX.
   always_comb begin
      w_ctrl = ctrl_of(w_sel);
      if (rst)
         w_ctrl = '{1'b0, 1'b0, 1'b1, 1'b1};
   end

   assign w_start = !w_ctrl.idex_bubble & bus.i_id_mdu_start;

   mdu_scoreboard #(
      .MDU_LAT (MDU_LAT)
   ) u_mdu (
      .clk     (clk),
      .rst     (rst),
      .i_start (w_start),
      .o_busy  (w_mdu_busy)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_stall_cnt <= '0;
      else if (!w_ctrl.pc_write && (r_stall_cnt != '1))
         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
   end

   assign bus.o_pc_write    = w_ctrl.pc_write;
   assign bus.o_ifid_write  = w_ctrl.ifid_write;
   assign bus.o_ifid_flush  = w_ctrl.ifid_flush;
   assign bus.o_idex_bubble = w_ctrl.idex_bubble;
   assign bus.o_mdu_busy    = w_mdu_busy;
   assign bus.o_stall_cnt   = r_stall_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed hazard scenarios,
// randomized traffic and counter saturation against a cycle-level model.
module tb_pipe_hazard_ctrl;
   localparam int LAT = 4;
   localparam int AW  = 5;
   localparam int CW  = 16;
   localparam longint SMAX = (64'd1 << CW) - 1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pipe_hazard_ctrl_if #(.REG_AW(AW), .CNT_W(CW)) bus ();

   pipe_hazard_ctrl #(
      .MDU_LAT (LAT),
      .REG_AW  (AW),
      .CNT_W   (CW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // model: cycle index, last busy cycle of the MDU, stall count
   longint cyc      = 0;
   longint busy_end = -1;
   longint m_stall  = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)",
                  tag, obs, exp, cyc);
      end
   endtask

   task automatic drive(input int rs, input int rt, input bit urs,
                        input bit urt, input bit ms, input bit mu,
                        input bit mr, input int rd, input bit rdr,
                        input bit rdy);
      bus.i_id_rs        = AW'(rs);
      bus.i_id_rt        = AW'(rt);
      bus.i_id_uses_rs   = urs;
      bus.i_id_uses_rt   = urt;
      bus.i_id_mdu_start = ms;
      bus.i_id_mdu_use   = mu;
      bus.i_ex_memread   = mr;
      bus.i_ex_rd        = AW'(rd);
      bus.i_ex_redirect  = rdr;
      bus.i_imem_ready   = rdy;
   endtask

   task automatic idle_in();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
   endtask

   task automatic model_reset();
      busy_end = cyc - 1;
      m_stall  = 0;
   endtask

   // called just after a posedge; checks this cycle, advances one edge
   task automatic step();
      bit busy, lu, haz;
      bit [3:0] e;
      busy = (cyc <= busy_end);
      lu = bus.i_ex_memread && (bus.i_ex_rd != 0) &&
           ((bus.i_id_uses_rs && bus.i_id_rs == bus.i_ex_rd) ||
            (bus.i_id_uses_rt && bus.i_id_rt == bus.i_ex_rd));
      haz = busy && (bus.i_id_mdu_start || bus.i_id_mdu_use);
      if (bus.i_ex_redirect)       e = 4'b1111;
      else if (lu || haz)          e = 4'b0001;
      else if (!bus.i_imem_ready)  e = 4'b0110;
      else                         e = 4'b1100;
      @(negedge clk);
      chk("pc_write",    32'(bus.o_pc_write),    32'(e[3]));
      chk("ifid_write",  32'(bus.o_ifid_write),  32'(e[2]));
      chk("ifid_flush",  32'(bus.o_ifid_flush),  32'(e[1]));
      chk("idex_bubble", 32'(bus.o_idex_bubble), 32'(e[0]));
      chk("mdu_busy",    32'(bus.o_mdu_busy),    32'(busy));
      chk("stall_cnt",   32'(bus.o_stall_cnt),   32'(m_stall));
      @(posedge clk);
      if (!e[0] && bus.i_id_mdu_start) busy_end = cyc + LAT;
      if (!e[3] && m_stall < SMAX) m_stall++;
      cyc++;
      #1;
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_pcw"},   32'(bus.o_pc_write),    32'd0);
      chk({tag, "_ifw"},   32'(bus.o_ifid_write),  32'd0);
      chk({tag, "_fl"},    32'(bus.o_ifid_flush),  32'd1);
      chk({tag, "_bub"},   32'(bus.o_idex_bubble), 32'd1);
      chk({tag, "_busy"},  32'(bus.o_mdu_busy),    32'd0);
      chk({tag, "_cnt"},   32'(bus.o_stall_cnt),   32'd0);
   endtask

   initial begin
      rst = 1'b1;
      idle_in();
      repeat (2) @(posedge clk);
      #1;
      chk_reset_outs("rst");
      @(posedge clk);
      cyc++;
      #1;
      rst = 1'b0;
      model_reset();

      // load-use: lw $2 in EX, add $3,$2,$4 in ID
      drive(2, 4, 1, 1, 0, 0, 1, 2, 0, 1);
      step();
      idle_in();
      step();
      chk("s1_cnt", 32'(bus.o_stall_cnt), 32'd1);

      // load to $0 never stalls
      drive(0, 0, 1, 1, 0, 0, 1, 0, 0, 1);
      step();
      chk("s2_cnt", 32'(bus.o_stall_cnt), 32'd1);

      // mult then dependent mfhi
      drive(1, 2, 1, 1, 1, 0, 0, 0, 0, 1);
      step();
      drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
      repeat (LAT) step();
      chk("s3_free", 32'(bus.o_idex_bubble), 32'd0);
      step();
      chk("s3_cnt", 32'(bus.o_stall_cnt), 32'd5);

      // redirect beats load-use and fetch wait; flushed mult never starts
      drive(2, 0, 1, 0, 1, 0, 1, 2, 1, 0);
      step();
      idle_in();
      chk("s4_busy", 32'(bus.o_mdu_busy), 32'd0);
      step();

      // three cycles of fetch wait
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) step();
      chk("s5_cnt", 32'(bus.o_stall_cnt), 32'd8);

      // async reset in the middle of an MDU op
      drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
      step();
      idle_in();
      repeat (2) step();
      chk("s6_pre", 32'(bus.o_mdu_busy), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk_reset_outs("s6");
      @(posedge clk);
      cyc++;
      #1;
      rst = 1'b0;
      model_reset();
      step();

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 1), $urandom_range(0, 1),
               ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 2) == 0), $urandom_range(0, 3),
               ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) != 0));
         step();
      end

      // saturation of the stall counter
      rst = 1'b1;
      idle_in();
      #1;
      rst = 1'b0;
      model_reset();
      @(posedge clk);
      cyc++;
      #1;
      model_reset();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (int'(SMAX) - 1) @(posedge clk);
      m_stall += SMAX - 1;
      cyc += SMAX - 1;
      #1;
      chk("sat_fffe", 32'(bus.o_stall_cnt), 32'(SMAX - 1));
      repeat (3) step();
      chk("sat_ffff", 32'(bus.o_stall_cnt), 32'(SMAX));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end
endmodule
